// File: rtl/ifu_prefetch.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module : ifu_prefetch
// Brief  : Instruction prefetch unit. Issues credit-limited fetch requests,
//          buffers in-order responses and flushes in-flight fetches on redirect.
// Rev    : 1.0
//------------------------------------------------------------------------------
module ifu_prefetch #(
  parameter int                   CPU_WIDTH  = 64,
  parameter int                   FIFO_DEPTH = 4,
  parameter logic [CPU_WIDTH-1:0] RESET_PC   = 64'h8000_0000
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  output logic                 o_req_valid,
  input  logic                 i_req_ready,
  output logic [CPU_WIDTH-1:0] o_req_addr,
  input  logic                 i_rsp_valid,
  input  logic [CPU_WIDTH-1:0] i_rsp_data,
  output logic                 o_ins_valid,
  input  logic                 i_ins_ready,
  output logic [31:0]          o_ins,
  output logic [CPU_WIDTH-1:0] o_pc,
  input  logic                 i_redirect,
  input  logic [CPU_WIDTH-1:0] i_redirect_pc
);

  localparam int                   c_ptr_w   = $clog2(FIFO_DEPTH);
  localparam int                   c_cnt_w   = c_ptr_w + 1;
  localparam logic [c_cnt_w:0]     c_depth   = (c_cnt_w + 1)'(FIFO_DEPTH);
  localparam logic [CPU_WIDTH-1:0] c_pc_step = CPU_WIDTH'(4);
  localparam logic [c_cnt_w-1:0]   c_one     = c_cnt_w'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    FLUSH = 2'd2
  } state_t;

  state_t               r_state, w_state_nxt;
  logic [CPU_WIDTH-1:0] r_fetch_pc, r_rsp_pc;
  logic [c_cnt_w-1:0]   r_outstanding, r_discard, r_count;
  logic [c_cnt_w-1:0]   w_out_nxt, w_discard_nxt;
  logic [c_ptr_w-1:0]   r_wptr, r_rptr;
  logic [CPU_WIDTH-1:0] r_fifo_pc  [FIFO_DEPTH];
  logic [31:0]          r_fifo_ins [FIFO_DEPTH];

  logic                 w_accept, w_rsp, w_push, w_pop, w_credit_ok;
  logic [CPU_WIDTH-1:0] w_target;
  logic [31:0]          w_word;
  logic                 w_unused;

  assign w_unused    = ^i_redirect_pc[1:0];
  assign w_credit_ok = ({1'b0, r_outstanding} + {1'b0, r_count}) < c_depth;
  assign o_req_valid = (r_state == FETCH) && w_credit_ok;
  assign o_req_addr  = r_fetch_pc;
  assign w_accept    = o_req_valid && i_req_ready;
  // A response with nothing outstanding is spurious and must not disturb state.
  assign w_rsp       = i_rsp_valid && (r_outstanding != '0);
  assign w_push      = w_rsp && (r_state == FETCH) && !i_redirect;
  assign w_pop       = o_ins_valid && i_ins_ready && !i_redirect;
  assign w_target    = {i_redirect_pc[CPU_WIDTH-1:2], 2'b00};
  assign w_word      = r_rsp_pc[2] ? i_rsp_data[63:32] : i_rsp_data[31:0];

  assign o_ins_valid = (r_count != '0);
  assign o_ins       = r_fifo_ins[r_rptr];
  assign o_pc        = r_fifo_pc[r_rptr];

  always_comb begin
    w_out_nxt = r_outstanding;
    case ({w_accept, w_rsp})
      2'b10:   w_out_nxt = r_outstanding + c_one;
      2'b01:   w_out_nxt = r_outstanding - c_one;
      default: w_out_nxt = r_outstanding;
    endcase
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_discard_nxt = r_discard;
    case (r_state)
      IDLE:  w_state_nxt = FETCH;
      FETCH: w_state_nxt = FETCH;
      FLUSH: begin
        if (w_rsp) begin
          w_discard_nxt = r_discard - c_one;
          if (r_discard == c_one) w_state_nxt = FETCH;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
    // Everything still in flight after this edge belongs to the old stream.
    if (i_redirect) begin
      w_discard_nxt = w_out_nxt;
      w_state_nxt   = (w_out_nxt == '0) ? FETCH : FLUSH;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state       <= IDLE;
      r_outstanding <= '0;
      r_discard     <= '0;
      r_fetch_pc    <= RESET_PC;
      r_rsp_pc      <= RESET_PC;
    end else begin
      r_state       <= w_state_nxt;
      r_outstanding <= w_out_nxt;
      r_discard     <= w_discard_nxt;
      if (i_redirect) begin
        r_fetch_pc <= w_target;
        r_rsp_pc   <= w_target;
      end else begin
        if (w_accept) r_fetch_pc <= r_fetch_pc + c_pc_step;
        if (w_push)   r_rsp_pc   <= r_rsp_pc + c_pc_step;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else if (i_redirect) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + c_ptr_w'(1);
      if (w_pop)  r_rptr <= r_rptr + c_ptr_w'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + c_one;
        2'b01:   r_count <= r_count - c_one;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        r_fifo_pc[i]  <= '0;
        r_fifo_ins[i] <= '0;
      end
    end else if (w_push) begin
      r_fifo_pc[r_wptr]  <= r_rsp_pc;
      r_fifo_ins[r_wptr] <= w_word;
    end
  end

`ifndef SYNTHESIS
  a_rsp_expected: assert property (@(posedge i_clk) disable iff (!i_rst_n)
                                   i_rsp_valid |-> (r_outstanding != '0))
    else $error("ifu_prefetch: response received with no request outstanding");
`endif

endmodule
`default_nettype wire

// File: tb/tb_ifu_prefetch.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module : tb_ifu_prefetch
// Brief  : Self-checking bench for ifu_prefetch with an in-order memory model.
// Rev    : 1.0
//------------------------------------------------------------------------------
module tb_ifu_prefetch;

  localparam logic [63:0] c_rst_pc = 64'h8000_0000;

  logic        clk;
  logic        rst_n;
  logic        req_valid, req_ready;
  logic [63:0] req_addr;
  logic        rsp_valid;
  logic [63:0] rsp_data;
  logic        ins_valid, ins_ready;
  logic [31:0] ins;
  logic [63:0] pc;
  logic        redirect;
  logic [63:0] redirect_pc;

  ifu_prefetch #(.CPU_WIDTH(64), .FIFO_DEPTH(4), .RESET_PC(64'h8000_0000)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .o_req_valid(req_valid), .i_req_ready(req_ready), .o_req_addr(req_addr),
    .i_rsp_valid(rsp_valid), .i_rsp_data(rsp_data),
    .o_ins_valid(ins_valid), .i_ins_ready(ins_ready), .o_ins(ins), .o_pc(pc),
    .i_redirect(redirect), .i_redirect_pc(redirect_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Program image: the instruction at pc is its low 32 bits xor a fixed key.
  function automatic logic [31:0] f_ins(input logic [63:0] a);
    return a[31:0] ^ 32'h1357_9BDF;
  endfunction

  function automatic logic [63:0] f_dw(input logic [63:0] a);
    logic [63:0] b;
    b = {a[63:3], 3'b000};
    return {f_ins(b + 64'd4), f_ins(b)};
  endfunction

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  typedef struct packed {
    logic [63:0] addr;
    int unsigned due;
    int unsigned epoch;
  } mreq_t;

  mreq_t       mq[$];
  int unsigned cyc = 0;
  int unsigned epoch = 0;
  int unsigned bus_epoch = 0;
  int unsigned mem_lat = 1;
  int          inflight = 0;
  int          stale_cnt = 0;
  logic [63:0] acc_log[$];
  logic [63:0] pc_log[$];
  logic [31:0] ins_log[$];

  // Memory: in-order, one response per cycle, each no sooner than mem_lat cycles.
  always @(posedge clk) begin
    cyc++;
    #1;
    rsp_valid = 1'b0;
    rsp_data  = '0;
    if (rst_n && mq.size() > 0 && mq[0].due <= cyc) begin
      rsp_valid = 1'b1;
      rsp_data  = f_dw(mq[0].addr);
      bus_epoch = mq[0].epoch;
      void'(mq.pop_front());
    end
  end

  // Reference model: delivered instructions and accepted requests each form
  // a sequential stream starting at the latest redirect target.
  logic [63:0] exp_req = 64'h8000_0000;
  logic [63:0] exp_pc = 64'h8000_0000;
  logic [63:0] prev_addr = '0;
  logic        prev_stall = 1'b0;
  logic        redir_prev = 1'b0;

  always @(negedge clk) begin
    int n;
    if (!rst_n) begin
      mq.delete();
      exp_req    = c_rst_pc;
      exp_pc     = c_rst_pc;
      prev_stall = 1'b0;
      redir_prev = 1'b0;
      inflight   = 0;
    end else begin
      if (redir_prev) chk("no_stale_after_redirect", ins_valid, 0);
      if (prev_stall) chk("req_addr_hold", req_addr, prev_addr);
      if (ins_valid) begin
        chk("o_pc", pc, exp_pc);
        chk("o_ins", ins, f_ins(exp_pc));
        if (ins_ready && !redirect) begin
          pc_log.push_back(pc);
          ins_log.push_back(ins);
          exp_pc = exp_pc + 64'd4;
        end
      end
      if (req_valid && req_ready) begin
        n = 0;
        foreach (mq[i]) if (mq[i].epoch != epoch) n++;
        if (rsp_valid && bus_epoch != epoch) n++;
        chk("req_addr", req_addr, exp_req);
        chk("no_req_while_old_in_flight", n, 0);
        mq.push_back('{addr: req_addr, due: cyc + mem_lat, epoch: epoch});
        acc_log.push_back(req_addr);
        exp_req = exp_req + 64'd4;
        inflight++;
      end
      if (rsp_valid) begin
        inflight--;
        if (bus_epoch != epoch || redirect) stale_cnt++;
      end
      prev_stall = req_valid && !req_ready && !redirect;
      prev_addr  = req_addr;
      redir_prev = redirect;
      if (redirect) begin
        exp_req = {redirect_pc[63:2], 2'b00};
        exp_pc  = {redirect_pc[63:2], 2'b00};
        epoch++;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  task automatic wait_pc(input int n, input string nm);
    int k;
    k = 0;
    while (pc_log.size() < n && k < 300) begin step(); k++; end
    if (pc_log.size() < n) begin
      checks++; errors++;
      $display("FAIL %s timeout delivered=%0d required=%0d", nm, pc_log.size(), n);
    end
  endtask

  task automatic wait_acc(input int n, input string nm);
    int k;
    k = 0;
    while (acc_log.size() < n && k < 300) begin step(); k++; end
    if (acc_log.size() < n) begin
      checks++; errors++;
      $display("FAIL %s timeout accepted=%0d required=%0d", nm, acc_log.size(), n);
    end
  endtask

  task automatic wait_inflight(input int n, input string nm);
    int k;
    k = 0;
    while (inflight != n && k < 300) begin step(); k++; end
    if (inflight != n) begin
      checks++; errors++;
      $display("FAIL %s timeout inflight=%0d required=%0d", nm, inflight, n);
    end
  endtask

  function automatic logic [63:0] pc_at(input int i);
    return (i < pc_log.size()) ? pc_log[i] : '1;
  endfunction

  function automatic logic [63:0] acc_at(input int i);
    return (i < acc_log.size()) ? acc_log[i] : '1;
  endfunction

  function automatic logic [31:0] ins_at(input int i);
    return (i < ins_log.size()) ? ins_log[i] : '1;
  endfunction

  task automatic chk_reset_outputs(input string nm);
    chk({nm, "_req_valid"}, req_valid, 0);
    chk({nm, "_req_addr"}, req_addr, 64'h8000_0000);
    chk({nm, "_ins_valid"}, ins_valid, 0);
    chk({nm, "_ins"}, ins, 0);
    chk({nm, "_pc"}, pc, 0);
  endtask

  initial begin
    int pb, ab, s0, k, acc_now;
    rst_n       = 1'b1;
    req_ready   = 1'b1;
    ins_ready   = 1'b1;
    redirect    = 1'b0;
    redirect_pc = '0;
    rsp_valid   = 1'b0;
    rsp_data    = '0;
    #3 rst_n = 1'b0;
    #1 chk_reset_outputs("reset");
    step();
    step();
    rst_n = 1'b1;

    // Streaming fetch with a one-cycle memory.
    wait_pc(8, "stream");
    chk("stream_acc0", acc_at(0), 64'h8000_0000);
    chk("stream_acc1", acc_at(1), 64'h8000_0004);
    chk("stream_pc0", pc_at(0), 64'h8000_0000);
    chk("stream_pc1", pc_at(1), 64'h8000_0004);
    chk("stream_pc2", pc_at(2), 64'h8000_0008);
    chk("stream_ins0", ins_at(0), 32'h9357_9BDF);
    chk("stream_ins1", ins_at(1), 32'h9357_9BDB);
    chk("stream_ins2", ins_at(2), 32'h9357_9BD7);

    // Memory not ready: request address must hold.
    req_ready = 1'b0;
    apply_reset();
    step();
    ab = acc_log.size();
    pb = pc_log.size();
    for (int i = 0; i < 5; i++) begin
      chk("stall_req_valid", req_valid, 1);
      chk("stall_req_addr", req_addr, 64'h8000_0000);
      step();
    end
    req_ready = 1'b1;
    wait_pc(pb + 1, "stall_resume");
    chk("stall_first_acc", acc_at(ab), 64'h8000_0000);
    chk("stall_first_pc", pc_at(pb), 64'h8000_0000);

    // Decode stalled: exactly FIFO_DEPTH requests, then no loss on resume.
    ins_ready = 1'b0;
    apply_reset();
    ab = acc_log.size();
    pb = pc_log.size();
    repeat (15) step();
    chk("full_accepts", acc_log.size() - ab, 4);
    chk("full_req_valid", req_valid, 0);
    chk("full_ins_valid", ins_valid, 1);
    ins_ready = 1'b1;
    wait_pc(pb + 8, "full_drain");
    chk("full_pc3", pc_at(pb + 3), 64'h8000_000C);
    chk("full_pc4", pc_at(pb + 4), 64'h8000_0010);

    // Redirect with three fetches in flight.
    mem_lat = 4;
    wait_inflight(3, "redir_setup");
    s0 = stale_cnt;
    req_ready   = 1'b0;
    redirect    = 1'b1;
    redirect_pc = 64'h8000_1006;
    step();
    redirect  = 1'b0;
    req_ready = 1'b1;
    ab = acc_log.size();
    pb = pc_log.size();
    wait_acc(ab + 1, "redir_req");
    chk("redir_first_acc", acc_at(ab), 64'h8000_1004);
    wait_pc(pb + 1, "redir_pc");
    chk("redir_first_pc", pc_at(pb), 64'h8000_1004);
    chk("redir_first_ins", ins_at(pb), 32'h9357_8BDB);
    chk("redir_dropped", stale_cnt - s0, 3);

    // Redirect coincident with a response and a pop.
    mem_lat = 1;
    k = 0;
    while (!(rsp_valid && ins_valid && ins_ready) && k < 100) begin step(); k++; end
    chk("coinc_found", rsp_valid && ins_valid, 1);
    s0 = stale_cnt;
    acc_now = (req_valid && req_ready) ? 1 : 0;
    ab = inflight + acc_now;
    redirect    = 1'b1;
    redirect_pc = 64'h8000_2000;
    step();
    chk("coinc_fifo_empty", ins_valid, 0);
    redirect = 1'b0;
    pb = pc_log.size();
    wait_pc(pb + 1, "coinc_pc");
    chk("coinc_first_pc", pc_at(pb), 64'h8000_2000);
    chk("coinc_dropped", stale_cnt - s0, ab);

    // Reset mid-operation with two fetches in flight.
    mem_lat = 4;
    wait_inflight(2, "rst_setup");
    rst_n = 1'b0;
    #1 chk_reset_outputs("midreset");
    step();
    step();
    rst_n = 1'b1;
    ab = acc_log.size();
    pb = pc_log.size();
    wait_acc(ab + 1, "rst_req");
    chk("rst_first_acc", acc_at(ab), 64'h8000_0000);
    wait_pc(pb + 1, "rst_pc");
    chk("rst_first_pc", pc_at(pb), 64'h8000_0000);

    step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ifu_prefetch.md
IFU_PREFETCH -- requirements
Module: ifu_prefetch

Interface
REQ-001 Parameter CPU_WIDTH, 64, address/data width.
REQ-002 Parameter FIFO_DEPTH, 4, instruction buffer entries; power of 2, >=2.
REQ-003 Parameter RESET_PC, 64'h8000_0000, first fetch address.
REQ-004 Clocking SHALL be one clock; reset is asynchronous and active-low.
REQ-005 i_clk  in  1  sole clock, rising edge.
REQ-006 i_rst_n  in  1  asynchronous active-low reset.
REQ-007 o_req_valid  out  1  fetch request valid.
REQ-008 i_req_ready  in  1  memory accepts request.
REQ-009 o_req_addr  out  CPU_WIDTH  fetch PC, 4-byte aligned.
REQ-010 i_rsp_valid  in  1  read data valid; responses return in request order.
REQ-011 i_rsp_data  in  CPU_WIDTH  8-byte-aligned doubleword containing the fetched PC.
REQ-012 o_ins_valid  out  1  instruction available to decode.
REQ-013 i_ins_ready  in  1  decode consumes instruction.
REQ-014 o_ins  out  32  instruction word.
REQ-015 o_pc  out  CPU_WIDTH  PC of o_ins.
REQ-016 i_redirect  in  1  branch/jump/exception redirect pulse.
REQ-017 i_redirect_pc  in  CPU_WIDTH  redirect target.

Function
REQ-018 FSM states SHALL be IDLE, FETCH, FLUSH; IDLE->FETCH unconditionally one cycle after reset release.
REQ-019 Request accepted on o_req_valid & i_req_ready; fetch PC SHALL then increment by 4 (wraps modulo 2^CPU_WIDTH).
REQ-020 In FETCH, o_req_valid SHALL be 1 iff outstanding + fifo_count < FIFO_DEPTH; 0 in IDLE and FLUSH.
REQ-021 o_req_addr SHALL hold stable while o_req_valid & !i_req_ready.
REQ-022 outstanding counter: +1 on accept, -1 on response, both same cycle = no change; width clog2(FIFO_DEPTH)+1.
REQ-023 Response in FETCH SHALL push {rsp_pc, word} into FIFO; word = i_rsp_data[31:0] if rsp_pc[2]==0 else [63:32]; rsp_pc then +4.
REQ-024 o_ins_valid = FIFO non-empty; o_ins/o_pc = FIFO head; pop on o_ins_valid & i_ins_ready.
REQ-025 Push and pop in same cycle SHALL both occur at any occupancy; credit rule (REQ-020) guarantees no overflow.
REQ-026 First fetched instruction SHALL appear on o_ins no earlier than one cycle after its response (registered FIFO output).
REQ-027 i_redirect SHALL have priority over all events: FIFO emptied, pop ignored, fetch PC and rsp_pc <= {i_redirect_pc[CPU_WIDTH-1:2], 2'b00}.
REQ-028 On redirect, discard <= outstanding + accept_this_cycle - rsp_this_cycle; next state FETCH if zero, else FLUSH.
REQ-029 In FLUSH, each response SHALL decrement discard and be dropped; at discard reaching 0 -> FETCH next cycle.
REQ-030 Redirect while in FLUSH SHALL recompute discard per REQ-028 and update target; no stale word may reach o_ins.
REQ-031 Response with outstanding==0 SHALL be ignored and flagged by a simulation assertion.
REQ-032 Redirect in IDLE SHALL set target and proceed to FETCH.

Reset
REQ-033 On i_rst_n low, asynchronously: state IDLE, fetch PC and rsp_pc RESET_PC, FIFO empty, outstanding 0, discard 0.
REQ-034 Output reset values: o_req_valid 0, o_req_addr RESET_PC, o_ins_valid 0, o_ins 0, o_pc 0.
REQ-035 Reset asserted mid-operation SHALL discard all in-flight state; responses arriving during reset ignored.

Verification
REQ-036 Reset release, i_req_ready=1, 1-cycle memory, i_ins_ready=1 -> requests 0x80000000,0x80000004,...; o_pc sequence matches, o_ins = correct doubleword half.
REQ-037 i_ins_ready=0, memory always ready -> exactly FIFO_DEPTH requests issued, o_req_valid stays 0, FIFO full, no loss after ready returns.
REQ-038 i_req_ready held 0 for 5 cycles -> o_req_addr stable at 0x80000000, no outstanding increment.
REQ-039 3 requests outstanding, i_redirect to 0x80001006 -> 3 responses dropped in FLUSH, next request 0x80001004, first o_pc 0x80001004.
REQ-040 Redirect coincident with response and pop -> FIFO empty next cycle, discard = outstanding-1, no stale o_ins_valid.
REQ-041 i_rst_n pulsed low with 2 requests outstanding -> outputs at reset values immediately, fetch restarts at RESET_PC.
